// File: rtl/if_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package if_pkg;

    // One queued fetch result: the word and the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // addi x0, x0, 0 -- presented whenever the queue is empty.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // RUN: responses are accepted; KILL: the response of this cycle is dropped.
    typedef enum logic {
        RUN  = 1'b0,
        KILL = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_fifo.sv
// Prefetch queue: power-of-two FIFO of fetch entries with wrap-around
// pointers, synchronous flush and an occupancy count. The head is read
// from registered storage, so an entry shows up the cycle after its push.
module if_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         valid_o,
    output logic [CW-1:0] count_o
);

    localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0000_0000, instr: NOP_INSTR};

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;

    // Pointer and occupancy bookkeeping; flush and reset both empty the queue.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry storage carries data only, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= entry_i;
    end

    assign valid_o = (cnt_q != '0);
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : EMPTY_ENTRY;
    assign count_o = cnt_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch: issues one-cycle-latency memory reads while queue
// credit remains, queues {pc, instr} results, and handles redirects from
// execute by flushing the queue and killing any in-flight response.
module if_prefetch
    import if_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    output logic          ird_o,
    output logic [31:0]   iaddr_o,
    input  logic [31:0]   irdata_i,
    input  logic          branch_taken_i,
    input  logic [31:0]   jump_addr_i,
    output logic          instr_valid_o,
    output logic [31:0]   instr_o,
    output logic [31:0]   instr_pc_o,
    output logic [31:0]   instr_next_pc_o,
    input  logic          instr_ready_i,
    output logic [CW-1:0] count_o
);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q;
    logic [31:0]   req_pc_q;
    logic          inflight_q;
    logic [CW-1:0] count_q;
    logic [CW:0]   credit_sum;
    logic          push_en;
    logic          pop_en;
    fetch_entry_t  head;
    fetch_entry_t  resp_entry;

    // Outstanding request counts against capacity; a same-cycle pop does not.
    assign credit_sum = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign ird_o      = !reset_i && !branch_taken_i && (credit_sum < (CW+1)'(DEPTH));

    // A response is dropped if a redirect arrives with it or we are in KILL.
    assign push_en    = inflight_q && (state_q == RUN) && !branch_taken_i;
    assign pop_en     = instr_valid_o && instr_ready_i;
    assign resp_entry = '{pc: req_pc_q, instr: irdata_i};

    // Fetch PC: reset vector, redirect target, or sequential advance.
    always_ff @(posedge clk_i) begin
        if (reset_i)             pc_q <= RESET_PC & 32'hFFFF_FFFC;
        else if (branch_taken_i) pc_q <= jump_addr_i & 32'hFFFF_FFFC;
        else if (ird_o)          pc_q <= pc_q + 32'd4;
    end

    // Request tracking and FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            inflight_q <= 1'b0;
            state_q    <= RUN;
        end else begin
            inflight_q <= ird_o;
            state_q    <= state_d;
        end
    end

    // Remember which address the outstanding request was issued for.
    always_ff @(posedge clk_i) begin
        if (ird_o) req_pc_q <= pc_q;
    end

    // Enter KILL only when a redirect meets a request already in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (branch_taken_i && inflight_q) state_d = KILL;
            KILL:    state_d = (branch_taken_i && inflight_q) ? KILL : RUN;
            default: state_d = RUN;
        endcase
    end

    if_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push_en),
        .entry_i (resp_entry),
        .pop_i   (pop_en),
        .flush_i (branch_taken_i),
        .head_o  (head),
        .valid_o (instr_valid_o),
        .count_o (count_q)
    );

    assign iaddr_o         = pc_q;
    assign instr_o         = head.instr;
    assign instr_pc_o      = head.pc;
    assign instr_next_pc_o = head.pc + 32'd4;
    assign count_o         = count_q;

endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: expected PC streams are queued when
// reset release or a redirect is driven, and popped on every delivery.
module tb_if_prefetch;
    import if_pkg::*;

    localparam logic [31:0] KEY    = 32'hA5A5_0000;
    localparam logic [31:0] WRAPPC = 32'hFFFF_FFF8;

    logic        clk_i = 1'b0;
    logic        reset_i, branch_taken_i, instr_ready_i;
    logic [31:0] jump_addr_i;

    logic        ird, valid;
    logic [31:0] iaddr, irdata, instr, ipc, inext;
    logic [2:0]  count;

    logic        ird2, valid2;
    logic [31:0] iaddr2, irdata2, instr2, ipc2, inext2;
    logic [2:0]  count2;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;
    logic [31:0] sb[$];
    logic [31:0] sb2[$];

    always #5 clk_i = ~clk_i;

    // One-cycle-latency instruction memories returning addr ^ KEY.
    always @(posedge clk_i) begin
        irdata  <= iaddr ^ KEY;
        irdata2 <= iaddr2 ^ KEY;
    end

    if_prefetch #(.DEPTH(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .ird_o(ird), .iaddr_o(iaddr),
        .irdata_i(irdata), .branch_taken_i(branch_taken_i), .jump_addr_i(jump_addr_i),
        .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(ipc),
        .instr_next_pc_o(inext), .instr_ready_i(instr_ready_i), .count_o(count)
    );

    if_prefetch #(.DEPTH(4), .RESET_PC(WRAPPC)) dut2 (
        .clk_i(clk_i), .reset_i(reset_i), .ird_o(ird2), .iaddr_o(iaddr2),
        .irdata_i(irdata2), .branch_taken_i(1'b0), .jump_addr_i(32'h0),
        .instr_valid_o(valid2), .instr_o(instr2), .instr_pc_o(ipc2),
        .instr_next_pc_o(inext2), .instr_ready_i(1'b1), .count_o(count2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_load(input logic [31:0] base);
        sb.delete();
        for (int k = 0; k < 128; k++) sb.push_back(base + 32'(4 * k));
    endtask

    task automatic sb2_load(input logic [31:0] base);
        sb2.delete();
        for (int k = 0; k < 128; k++) sb2.push_back(base + 32'(4 * k));
    endtask

    // Sample at the falling edge: invariants, scoreboard pops, reloads.
    task automatic sample();
        logic [31:0] e;
        @(negedge clk_i);
        chk("iaddr_align", 32'(iaddr[1:0]), 32'h0);
        chk("count_le_depth", 32'(count <= 3'd4), 32'h1);
        chk("next_pc", inext, ipc + 32'd4);
        chk("no_push_full", 32'(dut.push_en && (count == 3'd4)), 32'h0);
        if (valid && instr_ready_i) begin
            if (sb.size() == 0) chk("sb_underflow", 32'h1, 32'h0);
            else begin
                e = sb.pop_front();
                chk("deliv_pc", ipc, e);
                chk("deliv_instr", instr, e ^ KEY);
                chk("deliv_next", inext, e + 32'd4);
                n_pop++;
            end
        end
        if (valid2) begin
            if (sb2.size() == 0) chk("sb2_underflow", 32'h1, 32'h0);
            else begin
                e = sb2.pop_front();
                chk("wrap_pc", ipc2, e);
                chk("wrap_instr", instr2, e ^ KEY);
                chk("wrap_next", inext2, e + 32'd4);
            end
        end
        if (reset_i) begin
            sb_load(32'h0);
            sb2_load(WRAPPC);
        end else if (branch_taken_i) begin
            sb_load(jump_addr_i & 32'hFFFF_FFFC);
        end
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset();
        chk("rst_ird", 32'(ird), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", ipc, 32'h0);
        chk("rst_next", inext, 32'h4);
        chk("rst_iaddr2", iaddr2, WRAPPC);
        chk("rst_valid2", 32'(valid2), 32'h0);
    endtask

    task automatic do_reset();
        reset_i = 1'b1; branch_taken_i = 1'b0;
        sample(); chk("rst_ird_now", 32'(ird), 32'h0); adv();
        sample(); check_reset(); adv();
    endtask

    initial begin
        int p0;
        reset_i = 1'b1; branch_taken_i = 1'b0; instr_ready_i = 1'b0; jump_addr_i = 32'h0;
        adv();
        do_reset();

        // Reset release, streaming with decode always ready.
        reset_i = 1'b0; instr_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            sample();
            if (c < 3) begin
                chk("rel_ird", 32'(ird), 32'h1);
                chk("rel_iaddr", iaddr, 32'(4 * c));
                chk("rel_iaddr2", iaddr2, WRAPPC + 32'(4 * c));
            end
            if (c == 1) chk("rel_valid_c1", 32'(valid), 32'h0);
            if (c == 2) begin
                chk("rel_valid_c2", 32'(valid), 32'h1);
                chk("rel_pc_c2", ipc, 32'h0);
            end
            adv();
        end

        // Stall mid-stream until the queue is full, then reset with it full.
        instr_ready_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (c == 9) begin
                chk("full_count", 32'(count), 32'h4);
                chk("full_ird", 32'(ird), 32'h0);
            end
            adv();
        end
        do_reset();

        // Stall from reset: head must stay at PC 0, then drain without gaps.
        reset_i = 1'b0; instr_ready_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (c >= 2) begin
                chk("stall_valid", 32'(valid), 32'h1);
                chk("stall_head", ipc, 32'h0);
                chk("stall_instr", instr, KEY);
            end
            if (c == 9) begin
                chk("stall_count", 32'(count), 32'h4);
                chk("stall_ird", 32'(ird), 32'h0);
            end
            adv();
        end
        instr_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            sample(); chk("drain_nogap", 32'(valid), 32'h1); adv();
        end

        // Redirect with count=3 and a request in flight.
        do_reset();
        reset_i = 1'b0; instr_ready_i = 1'b0;
        for (int c = 0; c < 4; c++) begin sample(); adv(); end
        branch_taken_i = 1'b1; jump_addr_i = 32'h0000_0103;
        sample();
        chk("br_count_before", 32'(count), 32'h3);
        chk("br_ird", 32'(ird), 32'h0);
        adv();
        branch_taken_i = 1'b0; instr_ready_i = 1'b1;
        sample();
        chk("br_iaddr", iaddr, 32'h0000_0100);
        chk("br_ird_next", 32'(ird), 32'h1);
        chk("br_count", 32'(count), 32'h0);
        chk("br_valid", 32'(valid), 32'h0);
        adv();
        p0 = n_pop;
        for (int c = 0; c < 8; c++) begin sample(); adv(); end
        chk("br_delivered", 32'((n_pop - p0) >= 4), 32'h1);

        // Redirect coincident with a pop, then a second redirect to 0x200.
        branch_taken_i = 1'b1; jump_addr_i = 32'h0000_0180;
        sample(); chk("pop_br_valid", 32'(valid), 32'h1); adv();
        jump_addr_i = 32'h0000_0200;
        sample(); chk("br2_valid", 32'(valid), 32'h0); adv();
        branch_taken_i = 1'b0;
        p0 = n_pop;
        for (int c = 0; c < 10; c++) begin sample(); adv(); end
        chk("br2_delivered", 32'((n_pop - p0) >= 6), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
